// File: rtl/trail_write_arbiter.sv
// rtl/trail_write_arbiter.sv - framebuffer write arbiter for two trail writers with round-start clear sweep
module trail_write_arbiter #(
  parameter logic [19:0] CLEAR_BASE  = 20'd0,
  parameter logic [19:0] CLEAR_WORDS = 20'd153600,
  parameter logic [3:0]  WDOG_MAX    = 4'd15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [2:0]  Game_State,
  input  logic        b_req,
  input  logic        r_req,
  input  logic [19:0] b_addr,
  input  logic [19:0] r_addr,
  input  logic [15:0] b_data,
  input  logic [15:0] r_data,
  input  logic        b_last,
  input  logic        r_last,
  output logic        b_gnt,
  output logic        r_gnt,
  output logic [19:0] fb_addr,
  output logic [15:0] fb_data,
  output logic        fb_we,
  output logic        clear_busy
);

  localparam logic [2:0] PLAYING = 3'b010;

  typedef enum logic [1:0] {IDLE, CLEAR, GNT_B, GNT_R} state_t;

  state_t      state;
  logic [2:0]  gs_q;
  logic        hist_valid;
  logic        last_blue;
  logic [19:0] clr_cnt;
  logic [3:0]  wdog;

  logic        playing;
  logic        round_start;
  logic        sel_req;
  logic [19:0] sel_addr;
  logic [15:0] sel_data;
  logic        sel_last;

  assign playing = (Game_State == PLAYING);
  // hist_valid keeps a Game_State held at PLAYING across reset release from looking like a new round
  assign round_start = hist_valid && playing && (gs_q != PLAYING);

  assign b_gnt      = (state == GNT_B);
  assign r_gnt      = (state == GNT_R);
  assign clear_busy = (state == CLEAR);

  always_comb begin
    sel_req  = 1'b0;
    sel_addr = 20'd0;
    sel_data = 16'd0;
    sel_last = 1'b0;
    if (state == GNT_B) begin
      sel_req  = b_req;
      sel_addr = b_addr;
      sel_data = b_data;
      sel_last = b_last;
    end else if (state == GNT_R) begin
      sel_req  = r_req;
      sel_addr = r_addr;
      sel_data = r_data;
      sel_last = r_last;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      last_blue  <= 1'b0;
      gs_q       <= 3'd0;
      hist_valid <= 1'b0;
      clr_cnt    <= 20'd0;
      wdog       <= 4'd0;
      fb_we      <= 1'b0;
      fb_addr    <= 20'd0;
      fb_data    <= 16'd0;
    end else begin
      gs_q       <= Game_State;
      hist_valid <= 1'b1;
      fb_we      <= 1'b0;
      if (round_start) begin
        // word 0 goes out on entry so clear_busy and fb_we line up cycle for cycle
        state   <= CLEAR;
        fb_we   <= 1'b1;
        fb_addr <= CLEAR_BASE;
        fb_data <= 16'd0;
        clr_cnt <= 20'd1;
        wdog    <= 4'd0;
      end else begin
        case (state)
          IDLE: begin
            wdog <= 4'd0;
            if (playing) begin
              if (b_req && (!r_req || !last_blue)) state <= GNT_B;
              else if (r_req)                      state <= GNT_R;
            end
          end
          CLEAR: begin
            if (clr_cnt == CLEAR_WORDS) begin
              state   <= IDLE;
              clr_cnt <= 20'd0;
            end else begin
              fb_we   <= 1'b1;
              fb_addr <= CLEAR_BASE + clr_cnt;
              fb_data <= 16'd0;
              clr_cnt <= clr_cnt + 20'd1;
            end
          end
          GNT_B, GNT_R: begin
            if (sel_req) begin
              fb_we   <= 1'b1;
              fb_addr <= sel_addr;
              fb_data <= sel_data;
              wdog    <= 4'd0;
              if (sel_last) begin
                state     <= IDLE;
                last_blue <= (state == GNT_B);
              end else if (!playing) begin
                state <= IDLE;
              end
            end else if (!playing) begin
              state <= IDLE;
              wdog  <= 4'd0;
            end else if ((wdog + 4'd1) == WDOG_MAX) begin
              state     <= IDLE;
              last_blue <= (state == GNT_B);
              wdog      <= 4'd0;
            end else begin
              wdog <= wdog + 4'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/trail_write_arbiter.md
TRAIL_WRITE_ARBITER -- requirements
Module: trail_write_arbiter

Interface
REQ-001 Parameter: CLEAR_BASE, 20'd0, first framebuffer word address cleared at round start.
REQ-002 Parameter: CLEAR_WORDS, 20'd153600, number of words cleared; legal range 1..1048575 minus CLEAR_BASE.
REQ-003 Parameter: WDOG_MAX, 4'd15, idle-cycle limit inside a granted burst.
REQ-004 Clk  in  1  system clock, 50 MHz; all logic on rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 Game_State  in  3  game phase; 3'b010 = playing.
REQ-007 b_req / r_req  in  1  blue / red trail writer requests the framebuffer port.
REQ-008 b_addr / r_addr  in  20  word address offered by the blue / red writer.
REQ-009 b_data / r_data  in  16  data word offered by the blue / red writer.
REQ-010 b_last / r_last  in  1  offered word is the final word of the burst.
REQ-011 b_gnt / r_gnt  out  1  blue / red owns the port this cycle.
REQ-012 fb_addr  out  20  framebuffer write address, registered.
REQ-013 fb_data  out  16  framebuffer write data, registered.
REQ-014 fb_we  out  1  framebuffer write enable, registered.
REQ-015 clear_busy  out  1  clear sweep in progress.

Function
REQ-016 The block SHALL be an FSM with states IDLE, CLEAR, GNT_B, GNT_R.
REQ-017 Round start: Game_State changes from any non-3'b010 value to 3'b010, detected against a registered copy. From IDLE this SHALL enter CLEAR on the next edge.
REQ-018 CLEAR SHALL drive fb_we=1, fb_data=16'h0000 and fb_addr=CLEAR_BASE+n for n=0..CLEAR_WORDS-1, one word per cycle with no gaps. On the last word it SHALL return to IDLE.
REQ-019 clear_busy SHALL be 1 exactly while in CLEAR, and b_gnt and r_gnt SHALL be 0 throughout CLEAR.
REQ-020 A round start while in GNT_B or GNT_R SHALL abort the burst (gnt low next cycle) and enter CLEAR. A round start already in CLEAR SHALL restart the count at n=0.
REQ-021 IDLE, not in CLEAR and Game_State=3'b010:
  - only one request high: that side is granted;
  - both high: the side not served last is granted;
  - the last-served pointer resets to red, so blue wins the first tie.
REQ-022 Grant latency: the req high sample in IDLE moves the FSM to GNT_x on that edge. gnt_x SHALL be 1 for every cycle in GNT_x, decoded from state.
REQ-023 Word accepted = gnt_x & req_x in the same cycle. The next cycle SHALL show fb_we=1 with that cycle's addr/data. When no word is accepted, fb_we SHALL be 0.
REQ-024 An accepted word with last_x=1 SHALL return the FSM to IDLE on that edge and update the last-served pointer. IDLE then lasts at least one cycle between bursts.
REQ-025 Inside GNT_x, req_x low SHALL increment a 4-bit watchdog; an accepted word clears it. When the watchdog reaches WDOG_MAX with req still low, the burst SHALL abort to IDLE with the pointer updated.
REQ-026 Game_State leaving 3'b010 while in GNT_x SHALL abort to IDLE next edge. The word accepted on that edge is still written. No grants SHALL be issued while Game_State!=3'b010.
REQ-027 Inputs of the non-granted requester SHALL never reach fb_*.
REQ-028 Address arithmetic SHALL be 20-bit unsigned; CLEAR_BASE+n wraps modulo 2^20.

Reset
REQ-029 On Reset=1 at an edge:
  - state SHALL go to IDLE and the last-served pointer to red;
  - the clear counter, watchdog and Game_State history register SHALL clear to 0;
  - fb_we=0, fb_addr=0, fb_data=0, clear_busy=0, b_gnt=0, r_gnt=0 SHALL hold from the next cycle.
REQ-030 Reset SHALL take priority over every other event, including mid-CLEAR and mid-burst. No write SHALL be issued in the cycle after Reset.
REQ-031 Game_State=3'b010 held through reset release SHALL NOT count as a round start; only a later transition triggers CLEAR.

Verification
REQ-032 CLEAR_WORDS=4: Game_State 000->010 -> clear_busy for 4 cycles, fb_we=1 with fb_addr 0,1,2,3 and fb_data 0, then IDLE.
REQ-033 Both requests rise together after reset -> b_gnt first. Blue 3-word burst (last on word 3) -> fb_we for 3 cycles, then one IDLE cycle, then r_gnt.
REQ-034 Blue granted and drops req for 15 cycles with WDOG_MAX=15 -> burst aborted, b_gnt=0, no fb_we during the gap.
REQ-035 Red granted at word 2 of 5, then Game_State 010->011 -> word 2 written, r_gnt=0 next cycle, no further writes.
REQ-036 Reset asserted at clear word n=100 -> fb_we=0 next cycle, clear_busy=0, FSM in IDLE. No CLEAR restarts while Game_State stays 010.
REQ-037 Round start during blue burst -> b_gnt drops next cycle and CLEAR begins at CLEAR_BASE.
